pl_reg_skid: RTL and testbench



---
 rtl/pl_reg_skid.sv | 109 ++++++++++
 tb/tb_pl_reg_skid.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pl_reg_skid.sv
// Pipeline-stage register with valid/ready handshake and 2-entry skid buffer; no comb path out_ready->in_ready.
// Optional perf counters (stall_cnt, bubble_cnt, width CW) are built only when PL_REG_PERF_EN is defined.
module pl_reg_skid #(
  parameter int unsigned   DW      = 96,
  parameter logic [DW-1:0] NOP_VAL = 'h13
`ifdef PL_REG_PERF_EN
  ,
  parameter int unsigned   CW      = 32
`endif
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
`ifdef PL_REG_PERF_EN
  ,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] bubble_cnt
`endif
);

  // state   | meaning
  // S_EMPTY | nothing held, main keeps last (or NOP) value
  // S_ONE   | main holds the payload presented downstream
  // S_TWO   | main presented, skid holds the next payload
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] main_q, skid_q;
  logic          in_fire, out_fire;
  logic          load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != S_EMPTY);
  assign in_ready  = (state != S_TWO);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = S_TWO;
        end else if (out_fire) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // Flush wins over everything; any accepted input this cycle is discarded.
    if (flush) state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= S_EMPTY;
      main_q <= NOP_VAL;
      skid_q <= NOP_VAL;
    end else begin
      state <= state_nxt;
      if (flush) begin
        main_q <= NOP_VAL;
        skid_q <= NOP_VAL;
      end else begin
        if (load_main_in)        main_q <= in_data;
        else if (load_main_skid) main_q <= skid_q;
        if (load_skid)           skid_q <= in_data;
      end
    end
  end

`ifdef PL_REG_PERF_EN
  // Saturating counters; flush does not clear them and counts on pre-flush handshake.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CW'(1);
      if (!out_valid && (bubble_cnt != '1))             bubble_cnt <= bubble_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pl_reg_skid.sv
// Self-checking bench for pl_reg_skid: directed scenarios plus random traffic against a queue model.
// Define PL_REG_PERF_EN to also exercise the perf counters (CW=4).
module tb_pl_reg_skid;
  localparam int DW = 96;
  localparam logic [DW-1:0] NOP = 96'h13;

  logic          clk = 1'b0;
  logic          clrn, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
`ifdef PL_REG_PERF_EN
  localparam int CW = 4;
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

`ifdef PL_REG_PERF_EN
  pl_reg_skid #(.DW(DW), .NOP_VAL(NOP), .CW(CW)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));
`else
  pl_reg_skid #(.DW(DW), .NOP_VAL(NOP)) dut (
    .clk(clk), .clrn(clrn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
`endif

  int checks = 0;
  int errors = 0;

  // Reference: a 2-deep FIFO of accepted payloads; out_data shows the head, or the last departed value.
  logic [DW-1:0] q[$];
  logic [DW-1:0] last;
  int            m_stall, m_bubble;

  task automatic model_reset();
    q.delete();
    last     = NOP;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  function automatic logic [DW-1:0] exp_data();
    return (q.size() > 0) ? q[0] : last;
  endfunction

  // Called at a negedge; drives one cycle, updates the model across the posedge, returns at the next negedge.
  task automatic cycle(input logic iv, input logic ordy, input logic fl, input logic [DW-1:0] d);
    bit fi, fo;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    fi = iv && (q.size() < 2);
    fo = (q.size() > 0) && ordy;
    if (q.size() > 0 && !ordy) m_stall = (m_stall < 15) ? m_stall + 1 : 15;
    if (q.size() == 0)         m_bubble = (m_bubble < 15) ? m_bubble + 1 : 15;
    @(posedge clk);
    if (fo) last = q.pop_front();
    if (fl) begin
      q.delete();
      last = NOP;
    end else if (fi) begin
      q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== NOP) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data, NOP); end
    clrn = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, DW'(i));
      checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, DW'(i)); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_hs[%0d] got ready=%b valid=%b exp 1/1", i, in_ready, out_valid); end
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = 96'hA; b = 96'hB; c = 96'hC;
    cycle(1'b1, 1'b1, 1'b0, a);
    checks++; if (out_data !== a || out_valid !== 1'b1) begin errors++; $display("FAIL bp_present_a got=%h/%b exp=%h/1", out_data, out_valid, a); end
    cycle(1'b1, 1'b0, 1'b0, b);
    checks++; if (out_data !== a || in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_b got=%h/%b exp=%h/0", out_data, in_ready, a); end
    cycle(1'b1, 1'b0, 1'b0, c);
    checks++; if (out_data !== a || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_a got=%h/%b exp=%h/0", out_data, in_ready, a); end
    cycle(1'b1, 1'b1, 1'b0, c);
    checks++; if (out_data !== b || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_b got=%h/%b exp=%h/1", out_data, in_ready, b); end
    cycle(1'b1, 1'b1, 1'b0, c);
    checks++; if (out_data !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_then_c got=%h/%b exp=%h/1", out_data, out_valid, c); end
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++; if (out_valid !== 1'b0 || out_data !== c) begin errors++; $display("FAIL bp_empty got=%h/%b exp=%h/0", out_data, out_valid, c); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b0, 1'b0, 96'hA1);
    cycle(1'b1, 1'b0, 1'b0, 96'hB2);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_two got=%b exp=0", in_ready); end
    cycle(1'b1, 1'b0, 1'b1, 96'hC3);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_hs got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
    checks++; if (out_data !== NOP) begin errors++; $display("FAIL flush_data got=%h exp=%h", out_data, NOP); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_drain();
    cycle(1'b1, 1'b1, 1'b0, 96'hD4);
    cycle(1'b0, 1'b1, 1'b0, 96'hFF);
    checks++; if (out_valid !== 1'b0 || out_data !== 96'hD4) begin errors++; $display("FAIL drain got=%h/%b exp=d4/0", out_data, out_valid); end
  endtask

  task automatic test_random();
    logic iv, ordy, fl;
    for (int i = 0; i < 400; i++) begin
      iv   = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 2) != 0);
      fl   = 1'($urandom_range(0, 15) == 0);
      cycle(iv, ordy, fl, {$urandom, $urandom, $urandom});
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, q.size() < 2); end
      checks++; if (out_data !== exp_data()) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, exp_data()); end
`ifdef PL_REG_PERF_EN
      checks++; if (stall_cnt !== CW'(m_stall) || bubble_cnt !== CW'(m_bubble)) begin errors++; $display("FAIL rand_perf[%0d] got=%h/%h exp=%h/%h", i, stall_cnt, bubble_cnt, CW'(m_stall), CW'(m_bubble)); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 96'hE5);
    cycle(1'b1, 1'b0, 1'b0, 96'hF6);
    checks++; if (in_ready !== 1'b0 || out_data !== 96'hE5) begin errors++; $display("FAIL rmid_setup got=%h/%b exp=e5/0", out_data, in_ready); end
    #2 clrn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_async_hs got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
    checks++; if (out_data !== NOP) begin errors++; $display("FAIL rmid_async_data got=%h exp=%h", out_data, NOP); end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 1'b0, 96'h77);
    checks++; if (out_data !== 96'h77 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_resume got=%h/%b exp=77/1", out_data, out_valid); end
  endtask

`ifdef PL_REG_PERF_EN
  task automatic test_perf();
    cycle(1'b1, 1'b0, 1'b0, 96'h88);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    checks++; if (stall_cnt !== 4'hF) begin errors++; $display("FAIL perf_stall_sat got=%h exp=f", stall_cnt); end
    checks++; if (bubble_cnt !== CW'(m_bubble)) begin errors++; $display("FAIL perf_bubble got=%h exp=%h", bubble_cnt, CW'(m_bubble)); end
    #2 clrn = 1'b0;
    #1;
    checks++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin errors++; $display("FAIL perf_reset got=%h/%h exp=0/0", stall_cnt, bubble_cnt); end
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_drain();
    test_random();
    test_reset_mid();
`ifdef PL_REG_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
